// File: rtl/axi_ar_credit_pkg.sv
// rtl/axi_ar_credit_pkg.sv - shared types and defaults for the AR credit scheduler
package axi_ar_credit_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } state_t;

    localparam int MAX_OUTSTANDING_DEF = 8;

endpackage

// File: rtl/axi_ar_credit_counter.sv
// rtl/axi_ar_credit_counter.sv - per-port outstanding-read counter with AR gating
module axi_ar_credit_counter
    import axi_ar_credit_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_arvalid,
    input  logic             i_arready,
    input  logic             i_dec,
    output logic             o_arvalid,
    output logic             o_arready,
    output logic             o_allow,
    output logic             o_inc,
    output logic             o_pend,
    output logic             o_zero,
    output logic             o_underflow,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;

    // A presented request keeps its admission until granted, whatever the drain state.
    assign o_allow     = r_pend | (i_run & (r_cnt < CNT_W'(MAX_OUTSTANDING)));
    assign o_arvalid   = i_arvalid & o_allow;
    assign o_arready   = i_arready & o_allow;
    assign o_inc       = o_arvalid & i_arready;
    assign o_zero      = (r_cnt == '0);
    assign o_underflow = i_dec & o_zero;
    assign o_pend      = r_pend;
    assign o_cnt       = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (o_inc) begin
                r_pend <= 1'b0;
            end else if (o_arvalid) begin
                r_pend <= 1'b1;
            end
            if (o_inc && !i_dec) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!o_inc && i_dec && !o_zero) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi_ar_credit_scheduler.sv
// rtl/axi_ar_credit_scheduler.sv - per-port AR credit gating with drain FSM; AXI_AR_CREDIT_ERR_EN enables sticky err_o
module axi_ar_credit_scheduler
    import axi_ar_credit_pkg::*;
#(
    parameter int N_TARG_PORT     = 7,
    parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
    parameter int AXI_ID_IN       = 16,
    parameter int AXI_ID_OUT      = AXI_ID_IN + LOG_N_TARG,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_TARG_PORT-1:0]       arvalid_i,
    output logic [N_TARG_PORT-1:0]       arready_o,
    output logic [N_TARG_PORT-1:0]       arvalid_o,
    input  logic [N_TARG_PORT-1:0]       arready_i,
    input  logic [AXI_ID_OUT-1:0]        rid_i,
    input  logic                         rvalid_i,
    input  logic                         rready_i,
    input  logic                         rlast_i,
    input  logic                         drain_req_i,
    output logic                         drain_ack_o,
    output logic [N_TARG_PORT*CNT_W-1:0] out_cnt_o,
    output logic                         err_o
);

    state_t                  r_state, w_state_nxt;
    logic                    w_run, w_r_fire, w_oor, w_quiet;
    logic [LOG_N_TARG-1:0]   w_port;
    logic [N_TARG_PORT-1:0]  w_dec, w_inc, w_pend, w_zero, w_underflow, w_allow;
    logic                    w_unused;

    assign w_port   = rid_i[AXI_ID_OUT-1:AXI_ID_IN];
    assign w_r_fire = rvalid_i & rready_i & rlast_i;
    assign w_oor    = w_r_fire & (32'(w_port) >= N_TARG_PORT);

    for (genvar g = 0; g < N_TARG_PORT; g++) begin : g_port
        assign w_dec[g] = w_r_fire & (32'(w_port) == g);

        axi_ar_credit_counter #(
            .MAX_OUTSTANDING(MAX_OUTSTANDING),
            .CNT_W          (CNT_W)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .i_run      (w_run),
            .i_arvalid  (arvalid_i[g]),
            .i_arready  (arready_i[g]),
            .i_dec      (w_dec[g]),
            .o_arvalid  (arvalid_o[g]),
            .o_arready  (arready_o[g]),
            .o_allow    (w_allow[g]),
            .o_inc      (w_inc[g]),
            .o_pend     (w_pend[g]),
            .o_zero     (w_zero[g]),
            .o_underflow(w_underflow[g]),
            .o_cnt      (out_cnt_o[g*CNT_W +: CNT_W])
        );
    end

    assign w_quiet = (&w_zero) & ~(|w_pend) & ~(|w_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A dropped request wins over quiescence so traffic resumes without a detour through IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (drain_req_i) w_state_nxt = DRAIN;
            DRAIN:   if (!drain_req_i) w_state_nxt = RUN;
                     else if (w_quiet) w_state_nxt = IDLE;
            IDLE:    if (!drain_req_i) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_run       = (r_state == RUN);
        drain_ack_o = (r_state == IDLE);
    end

`ifdef AXI_AR_CREDIT_ERR_EN
    logic                  r_err;
    logic [LOG_N_TARG-1:0] r_err_port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_port <= '0;
        end else if (!r_err && (w_oor || (|w_underflow))) begin
            r_err      <= 1'b1;
            r_err_port <= w_port;
        end
    end

    assign err_o    = r_err;
    assign w_unused = ^{r_err_port, w_allow, rid_i[AXI_ID_IN-1:0]};
`else
    assign err_o    = 1'b0;
    assign w_unused = ^{w_oor, w_underflow, w_allow, rid_i[AXI_ID_IN-1:0]};
`endif

endmodule
